serial_magnitude_compare_ctrl: RTL and testbench
================================================

Name: serial_magnitude_compare_ctrl

Overview:
Controller that compares two WIDTH-bit unsigned operands one bit per cycle. It works MSB first and drives a single 1-bit compare cell.
- Operands are captured on a start pulse and shifted MSB→LSB through the cell.
- The controller stops at the first differing bit, or after the LSB.
- It returns a 3-bit result with the team's one-hot greater/equal/less encoding.
- It sits between a requesting FSM and the 1-bit comparator, turning the combinational cell into a multi-bit sequential comparator with a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.
- EARLY_EXIT, 1: 1 finishes at the first differing bit; 0 always scans all WIDTH bits (fixed latency).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A; captured when start is accepted
- b_in  input  WIDTH  operand B; captured when start is accepted
- busy  output  1  high while in COMPARE
- done  output  1  one-cycle pulse; y is valid from this cycle
- y  output  3  result: y[2]=A>B, y[1]=A==B, y[0]=A<B; one-hot when valid

Behaviour:
- Reset is synchronous and active-high. While rst=1 at an edge:
  - state→IDLE
  - busy=0, done=0, y=3'b000
  - operand registers and index cleared
- States and transitions:
  - IDLE → COMPARE on start=1.
  - COMPARE → COMPARE while bits remain.
  - COMPARE → DONE on a decision.
  - DONE → IDLE unconditionally.
- IDLE:
  - When start=1 at edge t0: latch a_in/b_in, set index=WIDTH-1, set the running result to EQ.
  - busy=1 from t0+1.
- COMPARE, one bit per cycle:
  - The cell sees a_reg[index] and b_reg[index].
  - If the bits differ and EARLY_EXIT=1: latch GT or LT, go to DONE.
  - If the bits differ and EARLY_EXIT=0: latch GT/LT on the first difference only, and keep scanning.
  - If index==0: finalise and go to DONE; the result is EQ if no difference was ever seen.
  - Otherwise index decrements by 1. There is no wrap; index never goes below 0.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - y is updated on entry to DONE and held until the next accepted start completes.
- y changes only on DONE entry or on reset. It is never 3'b000 after the first completed compare.
- Latency, from start edge t0 to done high:
  - worst case, or always when EARLY_EXIT=0: t0+WIDTH+1
  - best case with EARLY_EXIT=1 (MSB differs): t0+2
- start is ignored in COMPARE and DONE. It is not queued. a_in/b_in changes during COMPARE have no effect.
- start held high continuously: a new compare is accepted in the IDLE cycle after DONE. Back-to-back throughput is one result per WIDTH+2 cycles worst case.
- Reset mid-operation aborts immediately. No done pulse is produced and y returns to 3'b000.
- WIDTH=1: a single COMPARE cycle; done at t0+2 regardless of EARLY_EXIT.
- Operands are unsigned. There is no arithmetic beyond the index decrement; index width is clog2(WIDTH), minimum 1 bit.

Decomposition:
- Shared package/header:
  - result codes CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001, CMP_NONE=3'b000
  - state encodings S_IDLE, S_COMPARE, S_DONE (2 bits)
- One sub-module: compare_bit_cell. It is a combinational 1-bit compare producing a one-hot GT/EQ/LT for the current bit pair, and is instantiated once. The controller holds the FSM, operand registers, index counter and result register.

Test Plan:
- EARLY_EXIT=1, A=8'hA5, B=8'hA5, start at t0 → busy high t0+1..t0+8; done pulse at t0+9; y=3'b010.
- EARLY_EXIT=1, A=8'h80, B=8'h7F → done at t0+2, y=3'b100. Same operands with EARLY_EXIT=0 → done at t0+9, y=3'b100.
- A=8'h3C, B=8'h3D (LSB differs) → y=3'b001 at t0+9. Then start pulsed at t0+3 → ignored: exactly one done, and the operands are unchanged.
- rst=1 at t0+4 during COMPARE (A=8'h00, B=8'hFF) → next cycle busy=0, done=0, y=3'b000; no done pulse follows. A new start after reset completes normally.
- WIDTH=1: pairs (0,0),(0,1),(1,0),(1,1) → y=010, 001, 100, 010, each with done at t0+2.
- start held high, sequence (5,9) then (9,5), WIDTH=4 → first y=3'b001, then y=3'b100. The second start is accepted the cycle after the first done; y holds between the done pulses.

Source files
------------

// File: rtl/serial_magnitude_compare_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator: one-hot result
// codes, controller state encoding and the single-bit compare function.
package serial_magnitude_compare_ctrl_pkg;

    // One-hot result codes: bit 2 = A>B, bit 1 = A==B, bit 0 = A<B.
    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    // Index register width: clog2(width), never narrower than one bit.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Magnitude relation of a single unsigned bit pair.
    function automatic logic [2:0] cmp_bit(input logic a, input logic b);
        logic [2:0] res;
        res = CMP_EQ;
        if (a && !b) begin
            res = CMP_GT;
        end else if (!a && b) begin
            res = CMP_LT;
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_magnitude_compare_ctrl_cell.sv
// Combinational 1-bit magnitude compare cell producing a one-hot
// GT/EQ/LT code for the current bit pair.
module compare_bit_cell
    import serial_magnitude_compare_ctrl_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [2:0] res_o
);

    // Decode the bit pair into its one-hot relation.
    always_comb begin
        // NOTE: default assignment first so no path leaves res_o unassigned (no latch).
        res_o = CMP_NONE;
        res_o = cmp_bit(a_i, b_i);
    end

endmodule

// File: rtl/serial_magnitude_compare_ctrl.sv
// Sequential multi-bit unsigned magnitude comparator: captures two operands
// on start, walks them MSB first through a 1-bit compare cell, and reports a
// one-hot GT/EQ/LT result with a one-cycle done pulse.
// WIDTH legal range is 1..32.
module serial_magnitude_compare_ctrl
    import serial_magnitude_compare_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [2:0]       y
);

    localparam int              IDX_W   = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       res_q;   // running result: first difference seen, else EQ
    logic [2:0]       y_q;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       bit_res;
    logic [2:0]       final_d; // result to publish when the scan ends at bit 0

    compare_bit_cell u_cell (
        .a_i   (a_q[idx_q]),
        .b_i   (b_q[idx_q]),
        .res_o (bit_res)
    );

    // At the last bit, an earlier recorded difference wins over this bit.
    assign final_d = (res_q == CMP_EQ) ? bit_res : res_q;

    // Controller FSM, operand/index registers and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: operand and index registers are plain flops, cleared here
            // together with the FSM so an aborted compare leaves no residue.
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            res_q   <= CMP_NONE;
            y_q     <= CMP_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        idx_q   <= IDX_MAX;
                        res_q   <= CMP_EQ;
                        busy_q  <= 1'b1;
                        state_q <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (bit_res != CMP_EQ && res_q == CMP_EQ) begin
                        res_q <= bit_res;
                    end
                    if (EARLY_EXIT && bit_res != CMP_EQ) begin
                        y_q     <= bit_res;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (idx_q == '0) begin
                        y_q     <= final_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

endmodule

// File: tb/tb_serial_magnitude_compare_ctrl.sv
// Self-checking bench: four comparator instances (8-bit early exit, 8-bit
// fixed latency, 1-bit, 4-bit) checked against an arithmetic reference.
module tb_serial_magnitude_compare_ctrl;

    logic            clk;
    logic            rst;
    logic [3:0]      start_v;
    logic [3:0][7:0] a_v;
    logic [3:0][7:0] b_v;
    logic [3:0]      busy_v;
    logic [3:0]      done_v;
    logic [3:0][2:0] y_v;

    int n_checks;
    int n_errors;

    serial_magnitude_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a_in(a_v[0]), .b_in(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .y(y_v[0]));
    serial_magnitude_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a_in(a_v[1]), .b_in(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .y(y_v[1]));
    serial_magnitude_compare_ctrl #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a_in(a_v[2][0:0]), .b_in(b_v[2][0:0]),
        .busy(busy_v[2]), .done(done_v[2]), .y(y_v[2]));
    serial_magnitude_compare_ctrl #(.WIDTH(4), .EARLY_EXIT(1'b1)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a_in(a_v[3][3:0]), .b_in(b_v[3][3:0]),
        .busy(busy_v[3]), .done(done_v[3]), .y(y_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int inst_width(input int n);
        case (n)
            2:       return 1;
            3:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit inst_early(input int n);
        return (n != 1);
    endfunction

    function automatic logic [7:0] width_mask(input int w);
        return 8'((16'd1 << w) - 16'd1);
    endfunction

    // Reference result: plain unsigned comparison.
    function automatic logic [2:0] ref_y(input logic [7:0] a, input logic [7:0] b);
        if (a > b) return 3'b100;
        if (a < b) return 3'b001;
        return 3'b010;
    endfunction

    // Reference latency (edges from the start edge to done visible).
    function automatic int ref_lat(input int w, input bit ee, input logic [7:0] a, input logic [7:0] b);
        if (!ee || a == b) return w + 1;
        for (int j = w - 1; j >= 0; j--) begin
            if (a[j] != b[j]) return w - j + 1;
        end
        return w + 1;
    endfunction

    // One compare on instance n; optional stray start pulse at cycle pulse_at.
    task automatic run_cmp(input int n, input logic [7:0] av, input logic [7:0] bv,
                           input int pulse_at, input string tag);
        int         w;
        logic [7:0] am;
        logic [7:0] bm;
        int         exp_lat;
        logic [2:0] exp_y;
        logic [2:0] prev_y;
        int         lat;
        int         dones;
        int         busy_err;
        int         hold_err;
        w       = inst_width(n);
        am      = av & width_mask(w);
        bm      = bv & width_mask(w);
        exp_lat = ref_lat(w, inst_early(n), am, bm);
        exp_y   = ref_y(am, bm);
        lat = 0; dones = 0; busy_err = 0; hold_err = 0;
        @(negedge clk);
        prev_y     = y_v[n];
        a_v[n]     = am;
        b_v[n]     = bm;
        start_v[n] = 1'b1;
        @(posedge clk);
        #1;
        start_v[n] = 1'b0;
        a_v[n]     = 8'($urandom);
        b_v[n]     = 8'($urandom);
        for (int k = 1; k <= exp_lat + 6; k++) begin
            @(negedge clk);
            start_v[n] = (k == pulse_at && k < exp_lat);
            if (done_v[n]) begin
                dones++;
                if (lat == 0) lat = k;
            end
            if (busy_v[n] !== (k < exp_lat)) busy_err++;
            if (k < exp_lat && y_v[n] !== prev_y) hold_err++;
        end
        start_v[n] = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_dones"}, 32'(dones), 32'd1);
        check({tag, "_y"}, 32'(y_v[n]), 32'(exp_y));
        check({tag, "_busy"}, 32'(busy_err), 32'd0);
        check({tag, "_yhold"}, 32'(hold_err), 32'd0);
    endtask

    initial begin
        int lat1;
        int k2;
        int dones;
        int hold_err;
        logic [2:0] y1;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start_v  = '0;
        a_v      = '0;
        b_v      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy_v), 32'd0);
        check("reset_done", 32'(done_v), 32'd0);
        check("reset_y", 32'(y_v), 32'd0);
        rst = 1'b0;

        // Directed cases from the plan.
        run_cmp(0, 8'hA5, 8'hA5, 0, "eq_a5");
        run_cmp(0, 8'h80, 8'h7F, 0, "msb_ee1");
        run_cmp(1, 8'h80, 8'h7F, 0, "msb_ee0");
        run_cmp(0, 8'h3C, 8'h3D, 3, "lsb_stray");
        run_cmp(1, 8'h3D, 8'h3C, 4, "lsb_ee0_stray");

        // Reset during COMPARE aborts with no done pulse.
        @(negedge clk);
        a_v[0] = 8'h00; b_v[0] = 8'hFF; start_v[0] = 1'b1;
        a_v[1] = 8'h00; b_v[1] = 8'hFF; start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy_v), 32'd0);
        check("abort_done", 32'(done_v), 32'd0);
        check("abort_y", 32'(y_v), 32'd0);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_v != 4'd0) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_cmp(0, 8'h00, 8'hFF, 0, "after_reset");

        // WIDTH=1 truth table.
        run_cmp(2, 8'd0, 8'd0, 0, "w1_00");
        run_cmp(2, 8'd0, 8'd1, 0, "w1_01");
        run_cmp(2, 8'd1, 8'd0, 0, "w1_10");
        run_cmp(2, 8'd1, 8'd1, 0, "w1_11");

        // start held high on the 4-bit instance: (5,9) then (9,5).
        @(negedge clk);
        a_v[3] = 8'd5; b_v[3] = 8'd9; start_v[3] = 1'b1;
        @(posedge clk);
        lat1 = 0;
        for (int k = 1; k <= 20 && lat1 == 0; k++) begin
            @(negedge clk);
            if (done_v[3]) lat1 = k;
        end
        y1 = y_v[3];
        check("held_lat1", 32'(lat1), 32'(ref_lat(4, 1'b1, 8'd5, 8'd9)));
        check("held_y1", 32'(y1), 32'(ref_y(8'd5, 8'd9)));
        a_v[3] = 8'd9; b_v[3] = 8'd5;
        @(negedge clk);
        check("held_idle_busy", 32'(busy_v[3]), 32'd0);
        check("held_idle_done", 32'(done_v[3]), 32'd0);
        k2 = 0; hold_err = 0;
        for (int k = lat1 + 2; k <= lat1 + 20 && k2 == 0; k++) begin
            @(negedge clk);
            if (done_v[3]) begin
                k2 = k;
                start_v[3] = 1'b0;
            end else if (y_v[3] !== y1) begin
                hold_err++;
            end
        end
        start_v[3] = 1'b0;
        check("held_lat2", 32'(k2), 32'(lat1 + 1 + ref_lat(4, 1'b1, 8'd9, 8'd5)));
        check("held_y2", 32'(y_v[3]), 32'(ref_y(8'd9, 8'd5)));
        check("held_yhold", 32'(hold_err), 32'd0);
        repeat (4) @(negedge clk);

        // Randomized compares across all instances.
        for (int i = 0; i < 40; i++) begin
            int         n;
            int         mode;
            logic [7:0] av;
            logic [7:0] bv;
            n    = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            av   = 8'($urandom);
            bv   = 8'($urandom);
            if (mode == 1) bv = av;
            if (mode == 2) bv = av ^ (8'd1 << $urandom_range(0, inst_width(n) - 1));
            run_cmp(n, av, bv, ($urandom_range(0, 1) == 1) ? 2 : 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
